// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register with operand forwarding mux, immediate
//            generation and single-bubble load-use hazard insertion.
// Revision : 1.0
// ============================================================================
module id_ex_stage #(
   parameter int          CNT_W  = 16,
   parameter logic [31:0] NOP_IR = 32'hF000_0000
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [31:0]      ir_i,
   input  logic             ir_valid_i,
   input  logic [31:0]      rf_a_i,
   input  logic [31:0]      rf_b_i,
   input  logic [1:0]       byp_is_i,
   input  logic [31:0]      byp_data_i,
   input  logic             ex_stall_i,
   input  logic             flush_i,
   output logic [31:0]      ex_ir_o,
   output logic [31:0]      ex_a_o,
   output logic [31:0]      ex_b_o,
   output logic [31:0]      ex_imm_o,
   output logic             ex_valid_o,
   output logic             if_stall_o,
   output logic [CNT_W-1:0] lu_cnt_o
);

   localparam logic [3:0] c_op_lw    = 4'd0;
   localparam logic [3:0] c_op_sw    = 4'd1;
   localparam logic [3:0] c_op_addu  = 4'd3;
   localparam logic [3:0] c_op_addiu = 4'd4;
   localparam logic [3:0] c_op_sll   = 4'd5;
   localparam logic [3:0] c_op_mul   = 4'd6;
   localparam logic [3:0] c_op_bge   = 4'd7;
   localparam logic [3:0] c_op_j     = 4'd8;
   localparam logic [3:0] c_op_muli  = 4'd9;

   logic [31:0]      r_ex_ir;
   logic [31:0]      r_ex_a;
   logic [31:0]      r_ex_b;
   logic [31:0]      r_ex_imm;
   logic             r_ex_valid;
   logic [CNT_W-1:0] r_lu_cnt;

   logic [3:0]  w_op;
   logic [4:0]  w_src1;
   logic [4:0]  w_src2;
   logic        w_has_src1;
   logic        w_has_src2;
   logic [4:0]  w_ex_dst;
   logic        w_lu;
   logic [31:0] w_imm;
   logic [31:0] w_a_next;
   logic [31:0] w_b_next;

   assign w_op = ir_i[31:28];

   // Source register fields of the instruction sitting in decode
   always_comb begin
      w_src1     = ir_i[22:18];
      w_src2     = ir_i[27:23];
      w_has_src1 = 1'b0;
      w_has_src2 = 1'b0;
      case (w_op)
         c_op_lw, c_op_addiu, c_op_sll, c_op_muli: begin
            w_has_src1 = 1'b1;
         end
         c_op_sw: begin
            w_has_src1 = 1'b1;
            w_has_src2 = 1'b1;
         end
         c_op_addu, c_op_mul: begin
            w_src2     = ir_i[17:13];
            w_has_src1 = 1'b1;
            w_has_src2 = 1'b1;
         end
         c_op_bge: begin
            w_src1     = ir_i[27:23];
            w_src2     = ir_i[22:18];
            w_has_src1 = 1'b1;
            w_has_src2 = 1'b1;
         end
         default: begin
            w_has_src1 = 1'b0;
            w_has_src2 = 1'b0;
         end
      endcase
   end

   assign w_ex_dst = r_ex_ir[27:23];
   assign w_lu     = r_ex_valid & (r_ex_ir[31:28] == c_op_lw) & ir_valid_i &
                     ((w_has_src1 & (w_src1 == w_ex_dst)) |
                      (w_has_src2 & (w_src2 == w_ex_dst)));

   always_comb begin
      case (w_op)
         c_op_j:   w_imm = {4'b0, ir_i[27:0]};
         c_op_sll: w_imm = {27'b0, ir_i[4:0]};
         default:  w_imm = {{14{ir_i[17]}}, ir_i[17:0]};
      endcase
   end

   assign w_a_next = byp_is_i[0] ? byp_data_i : rf_a_i;
   assign w_b_next = byp_is_i[1] ? byp_data_i : rf_b_i;

   assign if_stall_o = ~rst_i & ~flush_i & (ex_stall_i | w_lu);

   // Operand/immediate registers simply hold whenever a bubble is latched
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ex_ir    <= NOP_IR;
         r_ex_a     <= '0;
         r_ex_b     <= '0;
         r_ex_imm   <= '0;
         r_ex_valid <= 1'b0;
         r_lu_cnt   <= '0;
      end else if (flush_i) begin
         r_ex_ir    <= NOP_IR;
         r_ex_valid <= 1'b0;
      end else if (ex_stall_i) begin
         r_ex_ir    <= r_ex_ir;
         r_ex_valid <= r_ex_valid;
      end else if (w_lu) begin
         r_ex_ir    <= NOP_IR;
         r_ex_valid <= 1'b0;
         if (r_lu_cnt != '1) begin
            r_lu_cnt <= r_lu_cnt + CNT_W'(1);
         end
      end else if (!ir_valid_i) begin
         r_ex_ir    <= NOP_IR;
         r_ex_valid <= 1'b0;
      end else begin
         r_ex_ir    <= ir_i;
         r_ex_a     <= w_a_next;
         r_ex_b     <= w_b_next;
         r_ex_imm   <= w_imm;
         r_ex_valid <= 1'b1;
      end
   end

   assign ex_ir_o    = r_ex_ir;
   assign ex_a_o     = r_ex_a;
   assign ex_b_o     = r_ex_b;
   assign ex_imm_o   = r_ex_imm;
   assign ex_valid_o = r_ex_valid;
   assign lu_cnt_o   = r_lu_cnt;

endmodule
`default_nettype wire
